// File: rtl/dl_ctrl_if.sv
// Request/latch-drive bundle between a requester and dl_ctrl.
// The requester drives v/din; dl_ctrl drives rdy, the latch pins e/d and done.
interface dl_ctrl_if #(
  parameter int unsigned W = 1
);
  logic         v;
  logic [W-1:0] din;
  logic         rdy;
  logic         e;
  logic [W-1:0] d;
  logic         done;

  modport master (
    output v,
    output din,
    input  rdy,
    input  e,
    input  d,
    input  done
  );

  modport slave (
    input  v,
    input  din,
    output rdy,
    output e,
    output d,
    output done
  );
endinterface

// File: rtl/dl_ctrl.sv
// Write sequencer for a bank of dl D-latches: setup, enable pulse, then hold, with d frozen
// while e is high. Optional macro DL_CTRL_SKIP_EN skips rewrites of an unchanged value.
module dl_ctrl #(
  parameter int unsigned W         = 1,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned OPEN_CYC  = 3,
  parameter int unsigned HOLD_CYC  = 1
) (
  input logic     clk,
  input logic     rst_n,
  dl_ctrl_if.slave bus
);

  localparam int unsigned MaxSo  = (SETUP_CYC > OPEN_CYC) ? SETUP_CYC : OPEN_CYC;
  localparam int unsigned MaxCyc = (MaxSo > HOLD_CYC) ? MaxSo : HOLD_CYC;
  localparam int unsigned CntW   = $clog2(MaxCyc) + 1;

  // HOLD_CYC of 0 never loads the counter; clamp to avoid an underflowed constant.
  localparam int unsigned HoldLoad = (HOLD_CYC > 0) ? HOLD_CYC - 1 : 0;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StOpen,
    StHold
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            e_q;
  logic [W-1:0]    d_q;
  logic            done_q;
  logic            skip;
  logic            fin;

`ifdef DL_CTRL_SKIP_EN
  logic wr_ok_q;

  // The latch already holds d_q once a write has completed; an equal request needs no pulse.
  assign skip = wr_ok_q && (bus.din == d_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ok_q <= 1'b0;
    end else if (fin) begin
      wr_ok_q <= 1'b1;
    end
  end
`else
  assign skip = 1'b0;
`endif

  // Completion edge: the cycle after this edge carries the done pulse.
  always_comb begin
    fin = 1'b0;
    unique case (state_q)
      StIdle:  fin = bus.v && skip;
      StOpen:  fin = (cnt_q == '0) && (HOLD_CYC == 0);
      StHold:  fin = (cnt_q == '0);
      default: fin = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      e_q     <= 1'b0;
      d_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= fin;
      unique case (state_q)
        StIdle: begin
          if (bus.v && !skip) begin
            d_q     <= bus.din;
            cnt_q   <= CntW'(SETUP_CYC - 1);
            state_q <= StSetup;
          end
        end
        StSetup: begin
          if (cnt_q == '0) begin
            e_q     <= 1'b1;
            cnt_q   <= CntW'(OPEN_CYC - 1);
            state_q <= StOpen;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StOpen: begin
          if (cnt_q == '0) begin
            e_q <= 1'b0;
            if (HOLD_CYC > 0) begin
              cnt_q   <= CntW'(HoldLoad);
              state_q <= StHold;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StHold: begin
          if (cnt_q == '0) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.rdy  = (state_q == StIdle);
  assign bus.e    = e_q;
  assign bus.d    = d_q;
  assign bus.done = done_q;

endmodule
